// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that merges several byte-packet requesters onto one UART TX byte stream.
// A grant locks to one port until that port's last byte is accepted or the stall counter times out.
module uart_tx_arbiter #(
   parameter int NUM_PORTS      = 2,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic [NUM_PORTS-1:0]   req_valid,
   input  logic [8*NUM_PORTS-1:0] req_data,
   input  logic [NUM_PORTS-1:0]   req_last,
   output logic [NUM_PORTS-1:0]   req_ready,
   output logic [7:0]             tx_data,
   output logic                   tx_data_valid,
   input  logic                   tx_data_ready,
   output logic [NUM_PORTS-1:0]   grant,
   output logic                   busy,
   output logic                   timeout_pulse
);

   localparam int              OW          = $clog2(NUM_PORTS);
   localparam logic [31:0]     TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);
   localparam logic [OW-1:0]   LAST_PORT   = OW'(NUM_PORTS - 1);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t          r_state, w_state_next;
   logic [OW-1:0]   r_owner, w_owner_next;
   logic [OW-1:0]   r_last_grant, w_last_grant_next;
   logic [31:0]     r_stall_cnt, w_stall_cnt_next;
   logic [7:0]      r_tx_data, w_tx_data_next;
   logic            r_tx_valid, w_tx_valid_next;
   logic            r_timeout_pulse, w_timeout_pulse_next;

   logic [7:0]           w_port_data [NUM_PORTS];
   logic [NUM_PORTS-1:0] w_owner_onehot;
   logic [NUM_PORTS-1:0] w_upper_mask;
   logic [NUM_PORTS-1:0] w_upper_req;
   logic [OW-1:0]        w_rr_pick;
   logic                 w_sink_free;
   logic                 w_accept;
   logic                 w_owner_last;
   logic                 w_stall_hit;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         assign w_port_data[gi]    = req_data[8*gi +: 8];
         assign w_owner_onehot[gi] = (r_owner == OW'(gi));
         // Ports above the previous winner get first look in the rotation.
         assign w_upper_mask[gi]   = (OW'(gi) > r_last_grant);
      end
   endgenerate

   assign w_upper_req  = req_valid & w_upper_mask;
   assign w_sink_free  = !r_tx_valid || tx_data_ready;
   assign req_ready    = (r_state == LOCKED && w_sink_free) ? w_owner_onehot : '0;
   assign grant        = (r_state == LOCKED) ? w_owner_onehot : '0;
   assign w_accept     = |(req_valid & req_ready);
   assign w_owner_last = |(req_valid & req_last & w_owner_onehot);
   assign w_stall_hit  = (TIMEOUT_LIM != 32'd0) && (r_stall_cnt >= TIMEOUT_LIM - 32'd1);

   assign tx_data       = r_tx_data;
   assign tx_data_valid = r_tx_valid;
   assign timeout_pulse = r_timeout_pulse;
   assign busy          = (r_state == LOCKED) || r_tx_valid;

   // Lowest requester above last_grant wins; otherwise wrap to the lowest requester overall.
   always_comb begin
      w_rr_pick = '0;
      for (int j = NUM_PORTS - 1; j >= 0; j--) begin
         if (req_valid[j]) begin
            w_rr_pick = OW'(j);
         end
      end
      for (int j = NUM_PORTS - 1; j >= 0; j--) begin
         if (w_upper_req[j]) begin
            w_rr_pick = OW'(j);
         end
      end
   end

   always_comb begin
      w_state_next         = r_state;
      w_owner_next         = r_owner;
      w_last_grant_next    = r_last_grant;
      w_stall_cnt_next     = r_stall_cnt;
      w_tx_data_next       = r_tx_data;
      w_tx_valid_next      = r_tx_valid;
      w_timeout_pulse_next = 1'b0;

      if (r_tx_valid && tx_data_ready) begin
         w_tx_valid_next = 1'b0;
      end
      if (w_accept) begin
         w_tx_data_next  = w_port_data[r_owner];
         w_tx_valid_next = 1'b1;
      end

      case (r_state)
         IDLE: begin
            w_stall_cnt_next = '0;
            if (|req_valid) begin
               w_owner_next = w_rr_pick;
               w_state_next = LOCKED;
            end
         end
         LOCKED: begin
            // An accept always beats a timeout landing on the same edge.
            if (w_accept) begin
               w_stall_cnt_next = '0;
               if (w_owner_last) begin
                  w_state_next      = IDLE;
                  w_last_grant_next = r_owner;
               end
            end else if (w_stall_hit) begin
               w_state_next         = IDLE;
               w_last_grant_next    = r_owner;
               w_stall_cnt_next     = '0;
               w_timeout_pulse_next = 1'b1;
            end else if (r_stall_cnt != 32'hFFFF_FFFF) begin
               w_stall_cnt_next = r_stall_cnt + 32'd1;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state         <= IDLE;
         r_owner         <= '0;
         r_last_grant    <= LAST_PORT;
         r_stall_cnt     <= '0;
         r_tx_data       <= 8'h00;
         r_tx_valid      <= 1'b0;
         r_timeout_pulse <= 1'b0;
      end else begin
         r_state         <= w_state_next;
         r_owner         <= w_owner_next;
         r_last_grant    <= w_last_grant_next;
         r_stall_cnt     <= w_stall_cnt_next;
         r_tx_data       <= w_tx_data_next;
         r_tx_valid      <= w_tx_valid_next;
         r_timeout_pulse <= w_timeout_pulse_next;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a byte scoreboard checks every delivered byte,
// and directed steps cover reset, round-robin, back-pressure, timeout and mid-packet reset.
module tb_uart_tx_arbiter;

   localparam int NP = 2;

   logic            clk = 1'b0;
   logic            nrst;
   logic [NP-1:0]   req_valid;
   logic [8*NP-1:0] req_data;
   logic [NP-1:0]   req_last;
   logic [NP-1:0]   req_ready;
   logic [7:0]      tx_data;
   logic            tx_data_valid;
   logic            tx_data_ready;
   logic [NP-1:0]   grant;
   logic            busy;
   logic            timeout_pulse;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0]    sb_q[$];
   logic [NP-1:0] gexp_q[$];

   uart_tx_arbiter #(
      .NUM_PORTS      (NP),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk           (clk),
      .nrst          (nrst),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .tx_data       (tx_data),
      .tx_data_valid (tx_data_valid),
      .tx_data_ready (tx_data_ready),
      .grant         (grant),
      .busy          (busy),
      .timeout_pulse (timeout_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   // Samples at the falling edge, scores any byte handed to the sink, then advances one clock.
   task automatic tick(output logic [NP-1:0] acc, output logic [NP-1:0] g);
      logic [7:0] exp_b;
      @(negedge clk);
      acc = req_valid & req_ready;
      g   = grant;
      if (tx_data_valid && tx_data_ready) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            $error("FAIL sb_pop: observed byte 0x%0h required no transfer", tx_data);
         end else begin
            exp_b = sb_q.pop_front();
            chk("sb_data", 32'(tx_data), 32'(exp_b));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      logic [NP-1:0] a, g;
      tick(a, g);
   endtask

   task automatic drive(input int p, input logic [7:0] d, input logic l);
      req_valid[p]       = 1'b1;
      req_data[8*p +: 8] = d;
      req_last[p]        = l;
      sb_q.push_back(d);
   endtask

   task automatic wait_acc(input int p, input string tag);
      logic [NP-1:0] a, g;
      bit done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         tick(a, g);
         if (a[p]) done = 1'b1;
      end
      chk(tag, 32'(done), 1);
   endtask

   initial begin
      logic [NP-1:0] a, g, prev_g;
      int            idx [NP];
      bit            done;

      nrst          = 1'b1;
      req_valid     = '0;
      req_data      = '0;
      req_last      = '0;
      tx_data_ready = 1'b0;
      #2 nrst = 1'b0;
      #1;
      chk("rst_grant", 32'(grant), 0);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_valid", 32'(tx_data_valid), 0);
      chk("rst_data", 32'(tx_data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_pulse", 32'(timeout_pulse), 0);
      repeat (2) @(posedge clk);
      #1;

      // "m:" from port 0 with the sink always ready
      tx_data_ready = 1'b1;
      drive(0, 8'h6D, 1'b0);
      nrst = 1'b1;
      step();
      chk("t34_grant", 32'(grant), 1);
      chk("t34_ready", 32'(req_ready), 1);
      chk("t34_nodata", 32'(tx_data_valid), 0);
      step();
      chk("t34_byte0", 32'(tx_data), 32'h6D);
      chk("t34_valid0", 32'(tx_data_valid), 1);
      drive(0, 8'h3A, 1'b1);
      step();
      chk("t34_byte1", 32'(tx_data), 32'h3A);
      chk("t34_idle", 32'(grant), 0);
      req_valid = '0;
      req_last  = '0;
      step();
      chk("t34_valid_off", 32'(tx_data_valid), 0);
      chk("t34_busy_off", 32'(busy), 0);

      // two ports streaming 3-byte packets; fresh reset so port 0 goes first
      nrst = 1'b0;
      step();
      nrst = 1'b1;
      gexp_q.push_back(2'b01);
      gexp_q.push_back(2'b10);
      gexp_q.push_back(2'b01);
      gexp_q.push_back(2'b10);
      for (int pk = 0; pk < 2; pk++) begin
         for (int p = 0; p < NP; p++) begin
            for (int b = 0; b < 3; b++) begin
               sb_q.push_back(8'(8'h10 * (p + 1) + pk * 3 + b));
            end
         end
      end
      idx[0] = 0;
      idx[1] = 0;
      prev_g = '0;
      done   = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
         for (int p = 0; p < NP; p++) begin
            req_valid[p]       = (idx[p] < 6);
            req_data[8*p +: 8] = 8'(8'h10 * (p + 1) + idx[p]);
            req_last[p]        = (idx[p] % 3 == 2);
         end
         tick(a, g);
         if (prev_g == '0 && g != '0) begin
            if (gexp_q.size() == 0) begin
               n_checks++;
               $error("FAIL t35_grant: observed extra grant 0x%0h required none", g);
            end else begin
               chk("t35_grant", 32'(g), 32'(gexp_q.pop_front()));
            end
         end
         prev_g = g;
         for (int p = 0; p < NP; p++) begin
            if (a[p]) idx[p]++;
         end
         done = (idx[0] == 6) && (idx[1] == 6);
      end
      chk("t35_done", 32'(done), 1);
      req_valid = '0;
      req_last  = '0;
      step();
      step();
      chk("t35_drain", 32'(sb_q.size()), 0);
      chk("t35_grants_left", 32'(gexp_q.size()), 0);

      // sink back-pressure while 0x41 is held
      drive(0, 8'h41, 1'b0);
      step();
      chk("t36_grant", 32'(grant), 1);
      wait_acc(0, "t36_acc41");
      chk("t36_data", 32'(tx_data), 32'h41);
      tx_data_ready = 1'b0;
      drive(0, 8'h42, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick(a, g);
         chk("t36_noacc", 32'(a), 0);
         chk("t36_hold", 32'(tx_data), 32'h41);
         chk("t36_valid", 32'(tx_data_valid), 1);
         chk("t36_ready", 32'(req_ready), 0);
      end
      tx_data_ready = 1'b1;
      wait_acc(0, "t36_acc42");
      chk("t36_data42", 32'(tx_data), 32'h42);
      req_valid = '0;
      req_last  = '0;
      step();
      chk("t36_drain", 32'(sb_q.size()), 0);

      // port 1 stalls mid-packet until the 8-cycle timeout; port 0 waits
      drive(1, 8'h55, 1'b0);
      drive(0, 8'h66, 1'b1);
      step();
      chk("t37_grant", 32'(grant), 2);
      wait_acc(1, "t37_acc55");
      req_valid[1] = 1'b0;
      for (int i = 0; i < 7; i++) begin
         step();
         chk("t37_nopulse", 32'(timeout_pulse), 0);
         chk("t37_locked", 32'(grant), 2);
      end
      step();
      chk("t37_pulse", 32'(timeout_pulse), 1);
      chk("t37_released", 32'(grant), 0);
      step();
      chk("t37_pulse_once", 32'(timeout_pulse), 0);
      chk("t37_next_owner", 32'(grant), 1);
      wait_acc(0, "t37_acc66");
      req_valid = '0;
      req_last  = '0;

      // last byte accepted on the edge the stall count would hit the limit
      drive(1, 8'h77, 1'b0);
      step();
      chk("t38_grant", 32'(grant), 2);
      wait_acc(1, "t38_acc77");
      req_valid[1] = 1'b0;
      for (int i = 0; i < 7; i++) begin
         step();
      end
      chk("t38_still_locked", 32'(grant), 2);
      drive(1, 8'h78, 1'b1);
      tick(a, g);
      chk("t38_acc_last", 32'(a), 2);
      chk("t38_idle", 32'(grant), 0);
      chk("t38_nopulse", 32'(timeout_pulse), 0);
      chk("t38_data", 32'(tx_data), 32'h78);
      req_valid = '0;
      req_last  = '0;
      step();
      chk("t38_nopulse2", 32'(timeout_pulse), 0);

      // reset mid-packet with a byte held; port 0 must win afterwards
      drive(0, 8'h90, 1'b1);
      step();
      wait_acc(0, "t39_acc90");
      req_valid = '0;
      req_last  = '0;
      drive(1, 8'hA0, 1'b0);
      req_valid[0]  = 1'b1;
      req_data[7:0] = 8'h91;
      req_last[0]   = 1'b1;
      step();
      chk("t39_grant_p1", 32'(grant), 2);
      wait_acc(1, "t39_accA0");
      tx_data_ready = 1'b0;
      chk("t39_held", 32'(tx_data_valid), 1);
      #2 nrst = 1'b0;
      #1;
      chk("t39_rst_valid", 32'(tx_data_valid), 0);
      chk("t39_rst_data", 32'(tx_data), 0);
      chk("t39_rst_grant", 32'(grant), 0);
      chk("t39_rst_ready", 32'(req_ready), 0);
      chk("t39_rst_busy", 32'(busy), 0);
      chk("t39_rst_pulse", 32'(timeout_pulse), 0);
      void'(sb_q.pop_back());
      sb_q.push_back(8'h91);
      sb_q.push_back(8'hA1);
      req_data[15:8] = 8'hA1;
      req_last[1]    = 1'b1;
      tx_data_ready  = 1'b1;
      step();
      step();
      nrst = 1'b1;
      step();
      chk("t39_first_p0", 32'(grant), 1);
      wait_acc(0, "t39_acc91");
      req_valid[0] = 1'b0;
      req_last[0]  = 1'b0;
      step();
      chk("t39_then_p1", 32'(grant), 2);
      wait_acc(1, "t39_accA1");
      req_valid = '0;
      req_last  = '0;
      step();
      step();
      chk("t39_drain", 32'(sb_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, meaning the number of byte-stream requesters (legal 2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning the locked-packet stall limit in clk cycles (0 = timeout disabled).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  NUM_PORTS  per-port byte valid.
REQ-006 SHALL have port req_data  input  8*NUM_PORTS  per-port byte; port i on bits [8i+7:8i].
REQ-007 SHALL have port req_last  input  NUM_PORTS  per-port end-of-packet flag, qualified by req_valid.
REQ-008 SHALL have port req_ready  output  NUM_PORTS  per-port byte accept.
REQ-009 SHALL have port tx_data  output  8  byte to UartTx.
REQ-010 SHALL have port tx_data_valid  output  1  byte valid to UartTx.
REQ-011 SHALL have port tx_data_ready  input  1  UartTx can take a byte.
REQ-012 SHALL have port grant  output  NUM_PORTS  one-hot current owner; all-zero when IDLE.
REQ-013 SHALL have port busy  output  1  high when state is LOCKED or tx_data_valid is high.
REQ-014 SHALL have port timeout_pulse  output  1  one-cycle strobe when a lock is released by timeout.

Function
REQ-015 SHALL implement two states: IDLE and LOCKED.
REQ-016 In IDLE with any req_valid high, SHALL select the first valid port searching upward from (last_grant+1) mod NUM_PORTS, register it as owner, and enter LOCKED next cycle.
REQ-017 In IDLE, req_ready SHALL be all-zero, so no byte is accepted in the arbitration cycle.
REQ-018 req_ready[i] SHALL be high only when state is LOCKED, owner==i, and (tx_data_valid==0 or tx_data_ready==1); non-owners see 0.
REQ-019 A byte SHALL be accepted when req_valid[i] and req_ready[i] are both high at a clk edge.
REQ-020 On accept, tx_data SHALL load req_data of the owner and tx_data_valid SHALL be 1 the next cycle (one cycle latency).
REQ-021 tx_data_valid SHALL fall after a cycle with tx_data_ready high and no new accept; tx_data SHALL remain stable while tx_data_valid is high and tx_data_ready is low.
REQ-022 Back-to-back accepts SHALL be possible every cycle while tx_data_ready stays high.
REQ-023 Accepting a byte with req_last=1 SHALL return the arbiter to IDLE next cycle and set last_grant to the owner.
REQ-024 In LOCKED, the stall counter SHALL increment each cycle without an accept, clear on every accept, and clear on entering LOCKED.
REQ-025 When TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES, the arbiter SHALL go to IDLE, set last_grant to the owner, and assert timeout_pulse for exactly one cycle.
REQ-026 If a last-byte accept and a timeout coincide, the accept SHALL win, with no timeout_pulse.
REQ-027 A byte already in tx_data SHALL still be delivered after release by last or timeout, and the next owner's first byte SHALL wait per REQ-018.
REQ-028 The counter SHALL be 32 bits and saturate; no wrap.
REQ-029 Round-robin fairness: after port k releases, every other port with req_valid high SHALL be granted before k again.
REQ-030 req_valid dropping mid-packet SHALL NOT release the lock; only last or timeout releases it.

Reset
REQ-031 On nrst low, SHALL asynchronously force state to IDLE, owner and grant to 0, last_grant to NUM_PORTS-1 (port 0 has first priority), counter to 0, tx_data to 8'h00, tx_data_valid to 0, req_ready to 0, timeout_pulse to 0, and busy to 0.
REQ-032 Reset mid-packet or mid-handshake SHALL discard the held byte, with no transfer after release.
REQ-033 After nrst rises, arbitration SHALL begin on the first clk edge with nrst high.

Verification
REQ-034 Port0 sends "m:" with last on ':', tx_data_ready held high -> grant=01 then 0x6D, 0x3A on tx_data on consecutive cycles, IDLE after.
REQ-035 Both ports request 3-byte packets continuously -> grants alternate 0,1,0,1, and packets never interleave.
REQ-036 tx_data_ready low for 5 cycles with tx_data_valid=1, data 0x41 -> tx_data stays 0x41, req_ready=0, and there is no accept.
REQ-037 TIMEOUT_CYCLES=8, port1 locked and sends 1 byte with no last, then idles -> timeout_pulse after 8 stalled cycles, and waiting port0 is granted next.
REQ-038 Last-byte accept on the same edge the counter hits the limit -> IDLE, timeout_pulse stays 0.
REQ-039 nrst pulsed low mid-packet with tx_data_valid=1 -> all outputs 0 immediately, and port0 wins the first arbitration after release.
